// File: rtl/key_pkg.sv
// Shared defaults for the push-button conditioner: channel count and the
// stability window for the board clock and for fast simulation.
package key_pkg;

    localparam int N_KEYS_DEF       = 8;
    localparam int STABLE_CNT_BOARD = 500000;
    localparam int STABLE_CNT_SIM   = 4;

endpackage

// File: rtl/key_debounce_bit.sv
// One key channel: two-flop synchroniser, stability counter, debounced level
// and registered press/release pulses.
module key_debounce_bit #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = $clog2(STABLE_CNT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw_i,
    output logic key_db_o,
    output logic press_o,
    output logic press_set_o,
    output logic release_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;
    logic             rel_q;
    logic             rel_d;

    // Next-state for the counter, debounced level and edge pulses.
    always_comb begin
        cnt_d   = cnt_q;
        db_d    = db_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (sync2_q == db_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            // Level held long enough: accept it and emit the matching edge.
            db_d    = sync2_q;
            cnt_d   = {CNT_W{1'b0}};
            press_d = db_q & ~sync2_q;
            rel_d   = ~db_q & sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Channel state registers; idle (released) level out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= {CNT_W{1'b0}};
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= key_raw_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign key_db_o    = db_q;
    assign press_o     = press_q;
    assign press_set_o = press_d;
    assign release_o   = rel_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces N_KEYS active-low buttons and keeps a sticky, write-1-to-clear
// pending register of presses with a level interrupt.
module key_debounce
    import key_pkg::*;
#(
    parameter int N_KEYS     = N_KEYS_DEF,
    parameter int STABLE_CNT = STABLE_CNT_BOARD,
    parameter int CNT_W      = $clog2(STABLE_CNT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_db,
    output logic [N_KEYS-1:0] press,
    // "release" is a reserved word, hence the suffix.
    output logic [N_KEYS-1:0] release_o,
    input  logic              clr_we,
    input  logic [N_KEYS-1:0] clr_din,
    output logic [N_KEYS-1:0] pending,
    output logic              irq
);

    logic [N_KEYS-1:0] press_set_s;
    logic [N_KEYS-1:0] clr_mask_s;
    logic [N_KEYS-1:0] pending_d;
    logic [N_KEYS-1:0] pending_q;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce_bit #(
            .STABLE_CNT (STABLE_CNT),
            .CNT_W      (CNT_W)
        ) u_bit (
            .clk         (clk),
            .rst         (rst),
            .key_raw_i   (key_raw[g]),
            .key_db_o    (key_db[g]),
            .press_o     (press[g]),
            .press_set_o (press_set_s[g]),
            .release_o   (release_o[g])
        );
    end

    // Pending next-state; a press landing with its clear keeps the bit set.
    always_comb begin
        clr_mask_s = {N_KEYS{1'b0}};
        if (clr_we) begin
            clr_mask_s = clr_din;
        end else begin
            clr_mask_s = {N_KEYS{1'b0}};
        end
        pending_d = (pending_q & ~clr_mask_s) | press_set_s;
    end

    // Sticky pending flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= {N_KEYS{1'b0}};
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
    assign irq     = |pending_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with a 4-cycle stability window.
module tb_key_debounce;
    import key_pkg::*;

    localparam int NK = N_KEYS_DEF;
    localparam int SC = STABLE_CNT_SIM;
    localparam int CW = $clog2(SC + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_db;
    logic [NK-1:0] press;
    logic [NK-1:0] release_o;
    logic          clr_we;
    logic [NK-1:0] clr_din;
    logic [NK-1:0] pending;
    logic          irq;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] raw;
        logic       we;
        logic [7:0] din;
        logic [7:0] e_db;
        logic [7:0] e_press;
        logic [7:0] e_rel;
        logic [7:0] e_pend;
        logic       e_irq;
    } vec_t;

    vec_t vq[$];

    key_debounce #(.N_KEYS(NK), .STABLE_CNT(SC), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_raw   (key_raw),
        .key_db    (key_db),
        .press     (press),
        .release_o (release_o),
        .clr_we    (clr_we),
        .clr_din   (clr_din),
        .pending   (pending),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input logic [7:0] db, input logic [7:0] pr,
                           input logic [7:0] rl, input logic [7:0] pd, input logic iq);
        chk({nm, ".key_db"},  key_db,    db);
        chk({nm, ".press"},   press,     pr);
        chk({nm, ".release"}, release_o, rl);
        chk({nm, ".pending"}, pending,   pd);
        chk({nm, ".irq"},     {7'd0, irq}, {7'd0, iq});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b0;
        key_raw = 8'h00;
        clr_we  = 1'b0;
        clr_din = 8'h00;

        // Reset/press-all/release-all/clear sequence, one row per edge.
        for (int i = 0; i < 5; i++)
            vq.push_back('{8'h00, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0});
        vq.push_back('{8'h00, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b1});
        vq.push_back('{8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b1});
        for (int i = 0; i < 5; i++)
            vq.push_back('{8'hFF, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b1});
        vq.push_back('{8'hFF, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1});
        vq.push_back('{8'hFF, 1'b1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0});
        vq.push_back('{8'hFF, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0});

        cyc(3);
        chk_all("reset", 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            key_raw = vq[i].raw;
            clr_we  = vq[i].we;
            clr_din = vq[i].din;
            cyc(1);
            chk_all($sformatf("vec%0d", i), vq[i].e_db, vq[i].e_press,
                    vq[i].e_rel, vq[i].e_pend, vq[i].e_irq);
        end
        clr_we  = 1'b0;
        clr_din = 8'h00;

        // Clean press on key 3.
        key_raw = 8'hF7;
        cyc(5);
        chk_all("press3_pre", 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
        cyc(1);
        chk_all("press3", 8'hF7, 8'h08, 8'h00, 8'h08, 1'b1);
        cyc(1);
        chk_all("press3_held", 8'hF7, 8'h00, 8'h00, 8'h08, 1'b1);

        // Release key 3, then clear its pending bit.
        key_raw = 8'hFF;
        cyc(5);
        chk_all("rel3_pre", 8'hF7, 8'h00, 8'h00, 8'h08, 1'b1);
        cyc(1);
        chk_all("rel3", 8'hFF, 8'h00, 8'h08, 8'h08, 1'b1);
        clr_we  = 1'b1;
        clr_din = 8'h08;
        cyc(1);
        chk_all("clr3", 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
        clr_we  = 1'b0;
        clr_din = 8'h00;

        // Bounce on key 5: low 3, high 1, then low; single press after edge 9.
        for (int i = 0; i < 13; i++) begin
            key_raw = (i == 3) ? 8'hFF : 8'hDF;
            cyc(1);
            chk($sformatf("bounce_press%0d", i), press, (i == 9) ? 8'h20 : 8'h00);
        end
        chk_all("bounce_end", 8'hDF, 8'h00, 8'h00, 8'h20, 1'b1);

        // Press on key 2 collides with a clear of bits 2 and 5.
        key_raw = 8'hDB;
        cyc(5);
        chk("coll_pre.press", press, 8'h00);
        clr_we  = 1'b1;
        clr_din = 8'h24;
        cyc(1);
        chk_all("collision", 8'hDB, 8'h04, 8'h00, 8'h04, 1'b1);
        clr_we  = 1'b0;
        clr_din = 8'h00;
        cyc(1);
        chk_all("coll_after", 8'hDB, 8'h00, 8'h00, 8'h04, 1'b1);

        // Asynchronous reset two cycles into a count on key 0.
        key_raw = 8'hDA;
        cyc(4);
        #2 rst = 1'b0;
        #1;
        chk_all("async_rst", 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
        cyc(3);
        chk_all("rst_hold", 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        cyc(5);
        chk_all("redb_pre", 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
        cyc(1);
        chk_all("redb", 8'hDA, 8'h25, 8'h00, 8'h25, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
